vector_mem_sequencer: RTL and testbench

Multi-cycle controller for vector load/store instructions coming out of the decode stage. Memory has one N-bit lane port, so the block breaks each vector access into LANES single-lane accesses. It stalls the front of the pipeline while those accesses are in flight. For loads, it assembles the full vector and hands it to the vector register file write port.

---
 rtl/vector_mem_sequencer_if.sv | 37 +++
 rtl/vector_mem_sequencer.sv | 139 +++++++++++++
 tb/tb_vector_mem_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/vector_mem_sequencer_if.sv
// Vector memory sequencer bus bundle.
// Carries the decode-side instruction handshake, the single-lane memory port
// and the vector register file write port.
//   slave  : the sequencer (takes the instruction, drives memory and VRF)
//   master : the surrounding pipeline / memory model
interface vector_mem_sequencer_if #(
   parameter int N      = 16,
   parameter int LANES  = 4,
   parameter int ADDR_W = 16
);
   logic                  Start;
   logic                  IsStore;
   logic [ADDR_W-1:0]     BaseAddr;
   logic [LANES*N-1:0]    VecStoreData;
   logic                  MemReady;
   logic [N-1:0]          MemReadData;
   logic [ADDR_W-1:0]     MemAddr;
   logic [N-1:0]          MemWriteData;
   logic                  MemWriteEn;
   logic                  MemReadEn;
   logic                  Stall;
   logic [LANES*N-1:0]    VecLoadData;
   logic                  VecWriteEn;
   logic                  Busy;

   modport slave (
      input  Start, IsStore, BaseAddr, VecStoreData, MemReady, MemReadData,
      output MemAddr, MemWriteData, MemWriteEn, MemReadEn, Stall,
             VecLoadData, VecWriteEn, Busy
   );

   modport master (
      output Start, IsStore, BaseAddr, VecStoreData, MemReady, MemReadData,
      input  MemAddr, MemWriteData, MemWriteEn, MemReadEn, Stall,
             VecLoadData, VecWriteEn, Busy
   );
endinterface

// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer.
// Splits one vector memory instruction into LANES single-lane accesses on a
// one-lane memory port, stalls fetch/decode while they are in flight, and for
// loads assembles the returned lanes and writes the vector register file.
// Ports:
//   clk  : clock, all state changes on its rising edge
//   rst  : synchronous reset, active-low
//   bus  : vector_mem_sequencer_if.slave (instruction in, memory port,
//          VRF write port, Stall/Busy status)
//
// state  | meaning
// IDLE   | waiting for Start; Stall follows Start combinationally
// ACCESS | one lane access per accepted cycle, lane 0 .. LANES-1
// DRAIN  | load only: capture read data of the last lane
// DONE   | release stall; loads pulse VecWriteEn
module vector_mem_sequencer #(
   parameter int N      = 16,
   parameter int LANES  = 4,
   parameter int ADDR_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   vector_mem_sequencer_if.slave  bus
);
   localparam int LW = $clog2(LANES);
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DRAIN  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [LW-1:0]       lane_q;
   logic                pending_q;
   logic [LW-1:0]       pending_lane_q;
   logic                is_store_q;
   logic [ADDR_W-1:0]   base_q;
   logic [LANES*N-1:0]  store_data_q;
   logic [LANES*N-1:0]  vec_q;

   logic [ADDR_W-1:0]   mem_addr;
   logic [N-1:0]        mem_wdata;
   logic                mem_we, mem_re, stall, vec_we, busy;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         lane_q         <= '0;
         pending_q      <= 1'b0;
         pending_lane_q <= '0;
         is_store_q     <= 1'b0;
         base_q         <= '0;
         store_data_q   <= '0;
         vec_q          <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= 1'b0;
         // Read data lags acceptance by one cycle; the last lane lands in DRAIN.
         if (pending_q)
            vec_q[int'(pending_lane_q)*N +: N] <= bus.MemReadData;
         case (state_q)
            S_IDLE: begin
               if (bus.Start) begin
                  is_store_q   <= bus.IsStore;
                  base_q       <= bus.BaseAddr;
                  store_data_q <= bus.VecStoreData;
                  lane_q       <= '0;
               end
            end
            S_ACCESS: begin
               if (bus.MemReady) begin
                  lane_q <= lane_q + 1'b1;
                  if (!is_store_q) begin
                     pending_q      <= 1'b1;
                     pending_lane_q <= lane_q;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Everything is forced low while rst is asserted, including the
   // combinational Stall path from Start.
   always_comb begin
      state_d   = state_q;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      stall     = 1'b0;
      vec_we    = 1'b0;
      busy      = 1'b0;
      if (rst) begin
         busy = (state_q != S_IDLE);
         case (state_q)
            S_IDLE: begin
               stall = bus.Start;
               if (bus.Start)
                  state_d = S_ACCESS;
            end
            S_ACCESS: begin
               stall    = 1'b1;
               mem_addr = base_q + ADDR_W'(lane_q);
               if (is_store_q) begin
                  mem_we    = 1'b1;
                  mem_wdata = store_data_q[int'(lane_q)*N +: N];
               end else begin
                  mem_re = 1'b1;
               end
               if (bus.MemReady && lane_q == LAST_LANE)
                  state_d = is_store_q ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
               stall   = 1'b1;
               state_d = S_DONE;
            end
            S_DONE: begin
               vec_we  = !is_store_q;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign bus.MemAddr      = mem_addr;
   assign bus.MemWriteData = mem_wdata;
   assign bus.MemWriteEn   = mem_we;
   assign bus.MemReadEn    = mem_re;
   assign bus.Stall        = stall;
   assign bus.VecWriteEn   = vec_we;
   assign bus.Busy         = busy;
   assign bus.VecLoadData  = rst ? vec_q : '0;
endmodule

// File: tb/tb_vector_mem_sequencer.sv
module tb_vector_mem_sequencer;
   localparam int N = 16, LANES = 4, AW = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   vector_mem_sequencer_if #(.N(N), .LANES(LANES), .ADDR_W(AW)) bus ();
   vector_mem_sequencer #(.N(N), .LANES(LANES), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0, fails = 0;
   logic [15:0] mem [0:65535];
   logic [31:0] wlog [$];
   logic [15:0] alog [$];
   int vwe_cnt = 0, stall_cnt = 0;

   // behavioural model state: one outstanding vector op
   bit          m_busy = 0, m_store = 0, m_drained = 0;
   logic [15:0] m_base = '0;
   logic [63:0] m_data = '0, m_vec = '0, m_nvec = '0;
   int          m_lane = 0;
   bit          rd_pend = 0;
   logic [15:0] rd_addr = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : cmp
      logic [15:0] e_addr, e_wd;
      logic e_we, e_re, e_stall, e_vwe, e_busy, vchk;
      logic [63:0] e_vec;
      e_addr = '0; e_wd = '0; e_we = 0; e_re = 0; e_stall = 0; e_vwe = 0; e_busy = 0;
      vchk = 0; e_vec = m_vec;
      if (bus.MemWriteEn && bus.MemReady) wlog.push_back({bus.MemAddr, bus.MemWriteData});
      if (bus.MemReadEn) alog.push_back(bus.MemAddr);
      if (bus.VecWriteEn) vwe_cnt++;
      if (bus.Stall) stall_cnt++;
      if (!rst) begin
         m_busy = 0; m_vec = '0; rd_pend = 0; vchk = 1; e_vec = '0;
      end else begin
         rd_pend = 0;
         if (!m_busy) begin
            e_stall = bus.Start;
            vchk = 1;
            if (bus.Start) begin
               m_busy = 1; m_store = bus.IsStore; m_base = bus.BaseAddr;
               m_data = bus.VecStoreData; m_lane = 0; m_drained = 0;
               for (int i = 0; i < LANES; i++)
                  m_nvec[i*N +: N] = mem[16'(bus.BaseAddr + 16'(i))];
            end
         end else if (m_lane < LANES) begin
            e_stall = 1; e_busy = 1;
            e_addr = m_base + 16'(m_lane);
            if (m_store) begin
               e_we = 1; e_wd = m_data[m_lane*N +: N];
            end else begin
               e_re = 1;
            end
            if (bus.MemReady) begin
               if (m_store) mem[e_addr] = e_wd;
               else begin rd_pend = 1; rd_addr = e_addr; end
               m_lane++;
            end
         end else if (!m_store && !m_drained) begin
            e_stall = 1; e_busy = 1; m_drained = 1;
         end else begin
            e_busy = 1; e_vwe = !m_store;
            if (!m_store) m_vec = m_nvec;
            e_vec = m_vec; vchk = 1; m_busy = 0;
         end
      end
      chk("MemAddr", 64'(bus.MemAddr), 64'(e_addr));
      chk("MemWriteData", 64'(bus.MemWriteData), 64'(e_wd));
      chk("MemWriteEn", 64'(bus.MemWriteEn), 64'(e_we));
      chk("MemReadEn", 64'(bus.MemReadEn), 64'(e_re));
      chk("Stall", 64'(bus.Stall), 64'(e_stall));
      chk("VecWriteEn", 64'(bus.VecWriteEn), 64'(e_vwe));
      chk("Busy", 64'(bus.Busy), 64'(e_busy));
      if (vchk) chk("VecLoadData", bus.VecLoadData, e_vec);
   end

   task automatic step();
      @(posedge clk);
      #1;
      bus.MemReadData = rd_pend ? mem[rd_addr] : 16'($urandom);
   endtask

   // Presents one instruction; lat = cycles from Start to DONE (-1 on timeout).
   task automatic run_op(input bit st, input logic [15:0] base, input logic [63:0] data,
                         input logic [31:0] rdy, output int lat, output logic [63:0] vout);
      lat = -1; vout = '0;
      bus.Start = 1; bus.IsStore = st; bus.BaseAddr = base; bus.VecStoreData = data;
      bus.MemReady = rdy[0];
      for (int k = 0; k < 31; k++) begin
         @(negedge clk);
         if (bus.Busy && !bus.Stall) begin lat = k; vout = bus.VecLoadData; end
         step();
         bus.Start = 0; bus.IsStore = 1'($urandom); bus.BaseAddr = 16'($urandom);
         bus.VecStoreData = {$urandom, $urandom}; bus.MemReady = rdy[k+1];
         if (lat >= 0) break;
      end
      if (lat < 0) begin
         tests++; fails++;
         $display("FAIL op_timeout: got no DONE within 31 cycles expected DONE");
      end
   endtask

   initial begin
      int lat, s0, v0, w0;
      logic [63:0] v;
      bit sb [16], ss [16];
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[16'h0100] = 16'h1111; mem[16'h0101] = 16'h2222;
      mem[16'h0102] = 16'h3333; mem[16'h0103] = 16'h4444;
      bus.Start = 1; bus.IsStore = 0; bus.BaseAddr = '0; bus.VecStoreData = '0;
      bus.MemReady = 1; bus.MemReadData = '0;

      // reset with Start asserted: outputs must stay low
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_stall", 64'(bus.Stall), 64'd0);
         chk("rst_busy", 64'(bus.Busy), 64'd0);
         step();
      end
      rst = 1; bus.Start = 0;
      step();

      // 1: store, lanes in order, 5 stall cycles, no VecWriteEn
      wlog.delete(); s0 = stall_cnt; v0 = vwe_cnt;
      run_op(1, 16'h0010, 64'hDDDD_CCCC_BBBB_AAAA, '1, lat, v);
      chk("t1_latency", 64'(lat), 64'd5);
      chk("t1_stall_cycles", 64'(stall_cnt - s0), 64'd5);
      chk("t1_vwe", 64'(vwe_cnt - v0), 64'd0);
      chk("t1_nwrites", 64'(wlog.size()), 64'd4);
      if (wlog.size() == 4) begin
         chk("t1_w0", 64'(wlog[0]), 64'h0010_AAAA);
         chk("t1_w1", 64'(wlog[1]), 64'h0011_BBBB);
         chk("t1_w2", 64'(wlog[2]), 64'h0012_CCCC);
         chk("t1_w3", 64'(wlog[3]), 64'h0013_DDDD);
      end

      // 2: load, full-speed
      v0 = vwe_cnt;
      run_op(0, 16'h0100, '0, '1, lat, v);
      chk("t2_latency", 64'(lat), 64'd6);
      chk("t2_vec", v, 64'h4444_3333_2222_1111);
      chk("t2_vwe", 64'(vwe_cnt - v0), 64'd1);

      // 3: load with MemReady low on first lane-1 and lane-2 cycles
      alog.delete();
      run_op(0, 16'h0100, '0, 32'hFFFF_FFEB, lat, v);
      chk("t3_latency", 64'(lat), 64'd8);
      chk("t3_vec", v, 64'h4444_3333_2222_1111);
      chk("t3_addr_seq", {alog.size() == 6 ? 16'h0 : 16'hFFFF,
                          alog.size() == 6 ? {alog[1], alog[2], alog[4]} : 48'h0},
                         64'h0000_0101_0101_0102);

      // 4: address wrap-around
      wlog.delete();
      run_op(1, 16'hFFFE, 64'h4444_3333_2222_1111, '1, lat, v);
      chk("t4_nwrites", 64'(wlog.size()), 64'd4);
      if (wlog.size() == 4)
         chk("t4_addrs", {wlog[0][31:16], wlog[1][31:16], wlog[2][31:16], wlog[3][31:16]},
             64'hFFFE_FFFF_0000_0001);

      // 5: reset on the second ACCESS cycle of a load
      bus.Start = 1; bus.IsStore = 0; bus.BaseAddr = 16'h0200; bus.MemReady = 1;
      step(); bus.Start = 0;
      step(); rst = 0;
      step(); rst = 1;
      @(negedge clk);
      chk("t5_busy", 64'(bus.Busy), 64'd0);
      chk("t5_readen", 64'(bus.MemReadEn), 64'd0);
      chk("t5_vec", bus.VecLoadData, 64'd0);
      v0 = vwe_cnt;
      step();
      repeat (5) step();
      chk("t5_no_vwe", 64'(vwe_cnt - v0), 64'd0);
      run_op(0, 16'h0100, '0, '1, lat, v);
      chk("t5_relatency", 64'(lat), 64'd6);
      chk("t5_revec", v, 64'h4444_3333_2222_1111);

      // 6: Start held through a full store
      w0 = wlog.size();
      bus.IsStore = 1; bus.BaseAddr = 16'h0300; bus.VecStoreData = 64'h0123_4567_89AB_CDEF;
      bus.MemReady = 1;
      for (int k = 0; k < 16; k++) begin
         bus.Start = (k <= 6);
         @(negedge clk);
         sb[k] = bus.Busy; ss[k] = bus.Stall;
         step();
      end
      bus.Start = 0;
      chk("t6_done5", {62'd0, sb[5], ss[5]}, 64'b10);
      chk("t6_idle6", {62'd0, sb[6], ss[6]}, 64'b01);
      chk("t6_busy7", 64'(sb[7]), 64'd1);
      chk("t6_done11", {62'd0, sb[11], ss[11]}, 64'b10);
      chk("t6_idle12", 64'(sb[12]), 64'd0);
      chk("t6_nwrites", 64'(wlog.size() - w0), 64'd8);

      // random traffic against the model
      for (int t = 0; t < 300; t++) begin
         logic [15:0] base;
         repeat ($urandom_range(0, 3)) step();
         base = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                             : 16'($urandom);
         run_op(1'($urandom), base, {$urandom, $urandom}, $urandom | 32'h1111_1111, lat, v);
      end

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
